// File: rtl/prog_loader.sv
// prog_loader: fills 16-bit instruction memory from a length-prefixed byte stream, holding the core in reset until done.
// Define PROG_LOADER_CKSUM_EN to require a trailing XOR checksum byte after the data words.
module prog_loader #(
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_byte_valid,
  input  logic [7:0]        i_byte,
  output logic              o_byte_ready,
  output logic              o_wr,
  output logic [AWIDTH-1:0] o_waddr,
  output logic [15:0]       o_wdata,
  output logic              o_core_rst,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CKSUM, S_DONE, S_ERR
  } state_t;

  localparam int          CW      = AWIDTH + 1;
  localparam logic [16:0] MAX_LEN = 17'(1) << AWIDTH;
`ifdef PROG_LOADER_CKSUM_EN
  localparam state_t      S_LAST  = S_CKSUM;
`else
  localparam state_t      S_LAST  = S_DONE;
`endif

  state_t            state_q, state_d;
  logic [7:0]        hi_q, hi_d;
  logic [CW-1:0]     len_q, len_d;
  logic [CW-1:0]     idx_q, idx_d;
  logic              wr_q, wr_d;
  logic [AWIDTH-1:0] waddr_q, waddr_d;
  logic [15:0]       wdata_q, wdata_d;
`ifdef PROG_LOADER_CKSUM_EN
  logic [7:0]        cksum_q, cksum_d;
`endif

  logic          accept;
  logic [15:0]   len_word;
  logic [CW-1:0] idx_inc;

  assign accept   = i_byte_valid && o_byte_ready;
  assign len_word = {hi_q, i_byte};
  assign idx_inc  = idx_q + CW'(1);

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    len_d   = len_q;
    idx_d   = idx_q;
    wr_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
`ifdef PROG_LOADER_CKSUM_EN
    cksum_d = cksum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (i_start) begin
          state_d = S_LEN_HI;
          idx_d   = '0;
          waddr_d = '0;
`ifdef PROG_LOADER_CKSUM_EN
          cksum_d = '0;
`endif
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          hi_d    = i_byte;
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d = CW'(len_word);
          // Reject lengths that would overflow the address space before any write.
          if ({1'b0, len_word} > MAX_LEN) state_d = S_ERR;
          else if (len_word == 16'd0)     state_d = S_LAST;
          else                            state_d = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        if (accept) begin
          hi_d    = i_byte;
          state_d = S_DATA_LO;
`ifdef PROG_LOADER_CKSUM_EN
          cksum_d = cksum_q ^ i_byte;
`endif
        end
      end
      S_DATA_LO: begin
        if (accept) begin
          wr_d    = 1'b1;
          waddr_d = idx_q[AWIDTH-1:0];
          wdata_d = {hi_q, i_byte};
          idx_d   = idx_inc;
          state_d = (idx_inc == len_q) ? S_LAST : S_DATA_HI;
`ifdef PROG_LOADER_CKSUM_EN
          cksum_d = cksum_q ^ i_byte;
`endif
        end
      end
`ifdef PROG_LOADER_CKSUM_EN
      S_CKSUM: begin
        if (accept) state_d = (i_byte == cksum_q) ? S_DONE : S_ERR;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
`ifdef PROG_LOADER_CKSUM_EN
      cksum_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
`ifdef PROG_LOADER_CKSUM_EN
      cksum_q <= cksum_d;
`endif
    end
  end

  assign o_byte_ready = (state_q == S_LEN_HI)  || (state_q == S_LEN_LO) ||
                        (state_q == S_DATA_HI) || (state_q == S_DATA_LO) ||
                        (state_q == S_CKSUM);
  assign o_busy       = o_byte_ready;
  assign o_core_rst   = (state_q != S_DONE);
  assign o_done       = (state_q == S_DONE);
  assign o_err        = (state_q == S_ERR);
  assign o_wr         = wr_q;
  assign o_waddr      = waddr_q;
  assign o_wdata      = wdata_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: stream-level model predicts every write (cycle, address, data) and final status.
`timescale 1ns/1ps
module tb_prog_loader;
  localparam int AW = 8;
`ifdef PROG_LOADER_CKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_start = 1'b0;
  logic          i_byte_valid = 1'b0;
  logic [7:0]    i_byte = 8'h00;
  logic          o_byte_ready, o_wr, o_core_rst, o_busy, o_done, o_err;
  logic [AW-1:0] o_waddr;
  logic [15:0]   o_wdata;

  prog_loader #(.AWIDTH(AW)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_byte_valid(i_byte_valid), .i_byte(i_byte),
    .o_byte_ready(o_byte_ready), .o_wr(o_wr), .o_waddr(o_waddr), .o_wdata(o_wdata),
    .o_core_rst(o_core_rst), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint      cyc;
    int          addr;
    logic [15:0] data;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        log_q[$];
  logic [7:0] strm[$];
  longint     cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle write checker against the predicted write schedule.
  always @(negedge clk) begin
    logic exp_wr;
    wr_t  w;
    exp_wr = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
    chk("wr_strobe", o_wr, exp_wr);
    if (o_wr === 1'b1) begin
      w.cyc = cyc; w.addr = int'(o_waddr); w.data = o_wdata;
      log_q.push_back(w);
    end
    if (exp_wr) begin
      chk("waddr", o_waddr, exp_q[0].addr);
      chk("wdata", o_wdata, exp_q[0].data);
      void'(exp_q.pop_front());
    end
  end

  task automatic chk_reset_vals();
    chk("rst_core_rst", o_core_rst, 1);
    chk("rst_ready", o_byte_ready, 0);
    chk("rst_wr", o_wr, 0);
    chk("rst_waddr", o_waddr, 0);
    chk("rst_wdata", o_wdata, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_err, 0);
  endtask

  task automatic build(input int nfield, input int nwords, input bit bad);
    logic [7:0] x, b;
    strm.delete();
    strm.push_back(nfield[15:8]);
    strm.push_back(nfield[7:0]);
    x = 8'h00;
    for (int k = 0; k < 2 * nwords; k++) begin
      b = 8'($urandom);
      x ^= b;
      strm.push_back(b);
    end
`ifdef PROG_LOADER_CKSUM_EN
    strm.push_back(x ^ {7'b0, bad});
`else
    if (bad) x = 8'h00;
`endif
  endtask

  // Drive strm through a full load. gap<0 means random gaps 0..2.
  task automatic run_load(input int gap, input int start_at, input int abort_at);
    int         n, consume, g;
    bit         ok;
    logic [7:0] x;
    wr_t        e;
    n = int'({strm[0], strm[1]});
    x = 8'h00;
    if (n > (1 << AW)) begin
      consume = 2;
      ok = 1'b0;
    end else begin
      for (int k = 0; k < 2 * n; k++) x ^= strm[2 + k];
      consume = 2 + 2 * n + CK;
      ok = (CK == 0) || (strm[2 + 2 * n] == x);
    end
    log_q.delete();
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    chk("start_busy", o_busy, 1);
    chk("start_ready", o_byte_ready, 1);
    chk("start_core_rst", o_core_rst, 1);
    chk("start_done", o_done, 0);
    chk("start_err", o_err, 0);
    for (int i = 0; i < consume; i++) begin
      if (i == abort_at) begin
        i_byte_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_vals();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        return;
      end
      g = (gap < 0) ? int'($urandom_range(2, 0)) : gap;
      repeat (g) begin
        i_byte_valid = 1'b0;
        i_byte = 8'($urandom);
        @(negedge clk);
      end
      i_byte_valid = 1'b1;
      i_byte = strm[i];
      i_start = (i == start_at);
      chk("ready", o_byte_ready, 1);
      if (i >= 2 && i < 2 + 2 * n && ((i - 2) % 2 == 1)) begin
        e.cyc = cyc + 1; e.addr = (i - 3) / 2; e.data = {strm[i - 1], strm[i]};
        exp_q.push_back(e);
      end
      @(negedge clk);
      i_start = 1'b0;
    end
    i_byte_valid = 1'b0;
    chk("end_done", o_done, ok);
    chk("end_err", o_err, !ok);
    chk("end_core_rst", o_core_rst, !ok);
    chk("end_busy", o_busy, 0);
    repeat (3) begin
      i_byte_valid = 1'b1;
      i_byte = 8'($urandom);
      chk("end_ready", o_byte_ready, 0);
      @(negedge clk);
    end
    i_byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("writes_drained", exp_q.size(), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_reset_vals();
    rst = 1'b0;

    // Two-word image with known contents.
    strm = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef PROG_LOADER_CKSUM_EN
    strm.push_back(8'h40);
`endif
    run_load(0, -1, -1);
    chk("t1_nwr", log_q.size(), 2);
    chk("t1_a0", log_q[0].addr, 0);
    chk("t1_d0", log_q[0].data, 16'h1234);
    chk("t1_a1", log_q[1].addr, 1);
    chk("t1_d1", log_q[1].data, 16'hABCD);
    chk("t1_done", o_done, 1);
    chk("t1_core_rst", o_core_rst, 0);

`ifdef PROG_LOADER_CKSUM_EN
    strm = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    run_load(0, -1, -1);
    chk("t2_nwr", log_q.size(), 2);
    chk("t2_err", o_err, 1);
    chk("t2_done", o_done, 0);
    chk("t2_core_rst", o_core_rst, 1);
`endif

    // Oversized length.
    strm = {8'h01, 8'h01};
    run_load(0, -1, -1);
    chk("t3_nwr", log_q.size(), 0);
    chk("t3_err", o_err, 1);
    chk("t3_ready", o_byte_ready, 0);

    // Empty image.
    build(0, 0, 1'b0);
    run_load(1, -1, -1);
    chk("t4_nwr", log_q.size(), 0);
    chk("t4_done", o_done, 1);

    // i_start during DATA_HI is ignored.
    build(4, 4, 1'b0);
    run_load(0, 4, -1);
    chk("t5_nwr", log_q.size(), 4);

    // Reset while waiting for a high data byte.
    build(3, 3, 1'b0);
    run_load(0, -1, 4);
    chk("t6_nwr", log_q.size(), 1);
    repeat (2) @(negedge clk);
    chk("t6_idle_busy", o_busy, 0);
    chk("t6_idle_core_rst", o_core_rst, 1);

    // Full-depth image with a byte every third cycle.
    build(256, 256, 1'b0);
    run_load(2, -1, -1);
    chk("t7_nwr", log_q.size(), 256);
    chk("t7_first", log_q[0].addr, 0);
    chk("t7_last", log_q[255].addr, 255);
    chk("t7_done", o_done, 1);

    // Randomized images, lengths and gaps.
    for (int r = 0; r < 12; r++) begin
      int kind;
      kind = int'($urandom_range(3, 0));
      if (kind == 0) build(int'($urandom_range(65535, 257)), 0, 1'b0);
      else build(int'($urandom_range(20, 1)), 0, 1'b0);
      if (kind != 0) build(int'({strm[0], strm[1]}), int'({strm[0], strm[1]}), 1'($urandom_range(1, 0)));
      run_load(-1, -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
